pipeline_stall_control: RTL and testbench

Pipeline hazard sequencer for the 5-stage CPU, directly downstream of the load-use hazard detector. Converts its `loadOutputToALUInput` flag, the taken-branch flush from X, and the multi-cycle mult/div handshake into per-latch enable and bubble-insert controls for PC, F/D, D/X and X/M. Owns the mult/div start pulses and busy tracking, so the datapath only sees latch controls.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/pipeline_stall_control_if.sv | 31 +++
 rtl/pipeline_stall_control_multdiv_sequencer.sv | 80 ++++++++
 rtl/pipeline_stall_control.sv | 79 +++++++
 tb/tb_pipeline_stall_control.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the hazard sequencer: instruction field
// constants, the mult/div FSM state and the latch-control bundle.
package cpu_pkg;

  localparam logic [4:0] OP_ALU    = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  // Which hazard owns the latch controls this cycle, highest priority first.
  typedef enum logic [2:0] {
    SRC_OFF,
    SRC_MD,
    SRC_FLUSH,
    SRC_LOAD,
    SRC_RUN
  } stall_src_t;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic xm_en;
    logic fd_nop;
    logic dx_nop;
    logic xm_nop;
  } latch_ctrl_t;

  localparam latch_ctrl_t CTRL_OFF   = 7'b0000_000;
  localparam latch_ctrl_t CTRL_MD    = 7'b0001_001;
  localparam latch_ctrl_t CTRL_FLUSH = 7'b1111_110;
  localparam latch_ctrl_t CTRL_LOAD  = 7'b0011_010;
  localparam latch_ctrl_t CTRL_RUN   = 7'b1111_000;

  function automatic latch_ctrl_t ctrl_for(input stall_src_t src);
    case (src)
      SRC_MD:    ctrl_for = CTRL_MD;
      SRC_FLUSH: ctrl_for = CTRL_FLUSH;
      SRC_LOAD:  ctrl_for = CTRL_LOAD;
      SRC_RUN:   ctrl_for = CTRL_RUN;
      default:   ctrl_for = CTRL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stall_control_if.sv
// Hazard inputs and latch/mult-div controls between the datapath and the
// pipeline stall sequencer.
interface pipeline_stall_control_if;
  logic [31:0] IR_X;
  logic        loadOutputToALUInput;
  logic        branch_taken_X;
  logic        md_resultRDY;
  logic        pc_en;
  logic        fd_en;
  logic        dx_en;
  logic        xm_en;
  logic        fd_nop;
  logic        dx_nop;
  logic        xm_nop;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        md_busy;
  logic        md_timeout;

  modport master (
    output IR_X, loadOutputToALUInput, branch_taken_X, md_resultRDY,
    input  pc_en, fd_en, dx_en, xm_en, fd_nop, dx_nop, xm_nop,
    input  ctrl_MULT, ctrl_DIV, md_busy, md_timeout
  );

  modport slave (
    input  IR_X, loadOutputToALUInput, branch_taken_X, md_resultRDY,
    output pc_en, fd_en, dx_en, xm_en, fd_nop, dx_nop, xm_nop,
    output ctrl_MULT, ctrl_DIV, md_busy, md_timeout
  );
endinterface

// File: rtl/pipeline_stall_control_multdiv_sequencer.sv
// IDLE/BUSY sequencer for the multi-cycle mult/div unit: start pulses, busy
// tracking, cycle counter and forced release after MD_TIMEOUT busy cycles.
module multdiv_sequencer
  import cpu_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset_n,
  input  logic md_in_x,
  input  logic md_is_div,
  input  logic md_result_rdy,
  output logic md_stall,
  output logic ctrl_mult,
  output logic ctrl_div,
  output logic md_busy,
  output logic md_timeout
);

  localparam logic [6:0] CNT_LAST = 7'(MD_TIMEOUT - 1);

  md_state_t  state_q, state_d;
  logic [6:0] md_cnt_q, md_cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    md_stall   = 1'b0;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    md_timeout = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_in_x) begin
          ctrl_mult = !md_is_div;
          ctrl_div  = md_is_div;
          md_stall  = 1'b1;
          md_cnt_d  = '0;
          state_d   = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_result_rdy) begin
          state_d = MD_IDLE;
        end else if (md_cnt_q == CNT_LAST) begin
          md_timeout = 1'b1;
          state_d    = MD_IDLE;
        end else begin
          md_stall = 1'b1;
          md_cnt_d = md_cnt_q + 7'd1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    // Pulses are combinational, so they must be forced quiet while in reset.
    if (!reset_n) begin
      md_stall   = 1'b0;
      ctrl_mult  = 1'b0;
      ctrl_div   = 1'b0;
      md_timeout = 1'b0;
    end
  end

  assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipeline_stall_control.sv
// Pipeline hazard sequencer: priority mux of mult/div stall, branch flush and
// load-use stall into PC/F-D/D-X/X-M latch controls.
// Optional build macro: STALL_PERF_COUNTERS_EN adds stall/flush counters.
module pipeline_stall_control
  import cpu_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset_n,
  pipeline_stall_control_if.slave ctl
`ifdef STALL_PERF_COUNTERS_EN
  ,
  output logic [31:0] lw_stall_cycles,
  output logic [31:0] md_stall_cycles,
  output logic [31:0] flush_count
`endif
);

  logic        md_in_x;
  logic        md_is_div;
  logic        md_stall;
  logic        unused_ir;
  stall_src_t  src;
  latch_ctrl_t ctrl;

  assign md_is_div = (ctl.IR_X[6:2] == ALUOP_DIV);
  assign md_in_x   = (ctl.IR_X[31:27] == OP_ALU) &&
                     ((ctl.IR_X[6:2] == ALUOP_MUL) || md_is_div);
  assign unused_ir = ^{ctl.IR_X[26:7], ctl.IR_X[1:0]};

  multdiv_sequencer #(
    .MD_TIMEOUT (MD_TIMEOUT)
  ) u_seq (
    .clock         (clock),
    .reset_n       (reset_n),
    .md_in_x       (md_in_x),
    .md_is_div     (md_is_div),
    .md_result_rdy (ctl.md_resultRDY),
    .md_stall      (md_stall),
    .ctrl_mult     (ctl.ctrl_MULT),
    .ctrl_div      (ctl.ctrl_DIV),
    .md_busy       (ctl.md_busy),
    .md_timeout    (ctl.md_timeout)
  );

  always_comb begin
    src = SRC_RUN;
    if (!reset_n)                      src = SRC_OFF;
    else if (md_stall)                 src = SRC_MD;
    else if (ctl.branch_taken_X)       src = SRC_FLUSH;
    else if (ctl.loadOutputToALUInput) src = SRC_LOAD;
  end

  assign ctrl       = ctrl_for(src);
  assign ctl.pc_en  = ctrl.pc_en;
  assign ctl.fd_en  = ctrl.fd_en;
  assign ctl.dx_en  = ctrl.dx_en;
  assign ctl.xm_en  = ctrl.xm_en;
  assign ctl.fd_nop = ctrl.fd_nop;
  assign ctl.dx_nop = ctrl.dx_nop;
  assign ctl.xm_nop = ctrl.xm_nop;

`ifdef STALL_PERF_COUNTERS_EN
  // Each counter follows the winning source only, so overlapping hazards count once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lw_stall_cycles <= '0;
      md_stall_cycles <= '0;
      flush_count     <= '0;
    end else begin
      if (src == SRC_LOAD)  lw_stall_cycles <= lw_stall_cycles + 32'd1;
      if (src == SRC_MD)    md_stall_cycles <= md_stall_cycles + 32'd1;
      if (src == SRC_FLUSH) flush_count     <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Scenario testbench for pipeline_stall_control: expected controls are queued
// as each cycle's stimulus is driven and compared mid-cycle.
module tb_pipeline_stall_control;
  import cpu_pkg::*;

  localparam logic [31:0] I_ADD    = 32'h0044_2000;
  localparam logic [31:0] I_MUL    = 32'h0044_2018;
  localparam logic [31:0] I_DIV    = 32'h0044_201C;
  localparam logic [31:0] I_NONALU = 32'h4044_2018;

  localparam logic [6:0] L_OFF   = 7'b0000_000;
  localparam logic [6:0] L_MD    = 7'b0001_001;
  localparam logic [6:0] L_FLUSH = 7'b1111_110;
  localparam logic [6:0] L_LOAD  = 7'b0011_010;
  localparam logic [6:0] L_RUN   = 7'b1111_000;

  // {pc,fd,dx,xm enables, fd,dx,xm nops, mult, div, busy, timeout}
  typedef logic [10:0] out_t;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;
  out_t sb[$];
  out_t got;
  out_t exp_v;

  pipeline_stall_control_if bus ();

`ifdef STALL_PERF_COUNTERS_EN
  logic [31:0] lw_stall_cycles, md_stall_cycles, flush_count;
`endif

  pipeline_stall_control #(
    .MD_TIMEOUT (40)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ctl     (bus.slave)
`ifdef STALL_PERF_COUNTERS_EN
    ,
    .lw_stall_cycles (lw_stall_cycles),
    .md_stall_cycles (md_stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1);
  end

  function automatic out_t mk(input logic [6:0] l, input logic mult, input logic div,
                              input logic busy, input logic tmo);
    mk = {l, mult, div, busy, tmo};
  endfunction

  function automatic out_t sample();
    sample = {bus.pc_en, bus.fd_en, bus.dx_en, bus.xm_en, bus.fd_nop, bus.dx_nop,
              bus.xm_nop, bus.ctrl_MULT, bus.ctrl_DIV, bus.md_busy, bus.md_timeout};
  endfunction

  task automatic set_in(input logic [31:0] ir, input logic lu, input logic br, input logic rdy);
    bus.IR_X                 = ir;
    bus.loadOutputToALUInput = lu;
    bus.branch_taken_X       = br;
    bus.md_resultRDY         = rdy;
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic [31:0] ir, input logic lu, input logic br, input logic rdy,
                       input out_t e);
    @(posedge clock);
    #1;
    set_in(ir, lu, br, rdy);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(I_MUL, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(L_OFF, 0, 0, 0, 0));
      @(negedge clock);
      got = sample(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL reset cycle %0d: got %b required %b", k, got, exp_v);
      end
    end
    set_in(I_ADD, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    drive(I_ADD, 0, 0, 0, mk(L_RUN, 0, 0, 0, 0));
    @(negedge clock);
    got = sample(); exp_v = sb.pop_front(); vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release: got %b required %b", got, exp_v);
    end
  endtask

  task automatic test_mul();
    for (int k = 0; k <= 34; k++) begin
      if (k == 0)      exp_v = mk(L_MD, 1, 0, 0, 0);
      else if (k < 33) exp_v = mk(L_MD, 0, 0, 1, 0);
      else if (k == 33) exp_v = mk(L_RUN, 0, 0, 1, 0);
      else             exp_v = mk(L_RUN, 0, 0, 0, 0);
      drive((k <= 33) ? I_MUL : I_ADD, 0, 0, (k == 33), exp_v);
      @(negedge clock);
      got = sample(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL mul cycle %0d: got %b required %b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 5; k++) begin
      case (k)
        1:       drive(I_ADD, 1, 0, 0, mk(L_LOAD, 0, 0, 0, 0));
        3:       drive(I_ADD, 0, 0, 1, mk(L_RUN, 0, 0, 0, 0));  // stray ready in IDLE
        4:       drive(I_NONALU, 0, 0, 0, mk(L_RUN, 0, 0, 0, 0));
        default: drive(I_ADD, 0, 0, 0, mk(L_RUN, 0, 0, 0, 0));
      endcase
      @(negedge clock);
      got = sample(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL load_use cycle %0d: got %b required %b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_flush_priority();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(I_ADD, 1, 1, 0, mk(L_FLUSH, 0, 0, 0, 0));
        1: drive(I_ADD, 0, 1, 0, mk(L_FLUSH, 0, 0, 0, 0));
        2: drive(I_MUL, 1, 1, 0, mk(L_MD, 1, 0, 0, 0));
        3: drive(I_MUL, 0, 0, 1, mk(L_RUN, 0, 0, 1, 0));
        default: drive(I_ADD, 0, 0, 0, mk(L_RUN, 0, 0, 0, 0));
      endcase
      @(negedge clock);
      got = sample(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL flush_priority cycle %0d: got %b required %b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_div_timeout();
    for (int k = 0; k <= 41; k++) begin
      if (k == 0)       exp_v = mk(L_MD, 0, 1, 0, 0);
      else if (k < 40)  exp_v = mk(L_MD, 0, 0, 1, 0);
      else if (k == 40) exp_v = mk(L_RUN, 0, 0, 1, 1);
      else              exp_v = mk(L_RUN, 0, 0, 0, 0);
      drive((k <= 40) ? I_DIV : I_ADD, 0, 0, 0, exp_v);
      @(negedge clock);
      got = sample(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL div_timeout cycle %0d: got %b required %b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    for (int k = 0; k < 15; k++) begin
      if (k < 10) begin
        drive(I_MUL, 0, 0, 0, (k == 0) ? mk(L_MD, 1, 0, 0, 0) : mk(L_MD, 0, 0, 1, 0));
      end else if (k < 12) begin
        @(posedge clock);
        #1;
        set_in((k == 10) ? I_MUL : I_ADD, 1'b1, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        sb.push_back(mk(L_OFF, 0, 0, 0, 0));
      end else if (k == 12) begin
        drive(I_MUL, 0, 0, 0, mk(L_MD, 1, 0, 0, 0));
      end else if (k == 13) begin
        drive(I_MUL, 0, 0, 1, mk(L_RUN, 0, 0, 1, 0));
      end else begin
        drive(I_ADD, 0, 0, 0, mk(L_RUN, 0, 0, 0, 0));
      end
      @(negedge clock);
      got = sample(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_busy cycle %0d: got %b required %b", k, got, exp_v);
      end
      if (k == 11) begin
        set_in(I_ADD, 1'b0, 1'b0, 1'b0);
        #1 reset_n = 1'b1;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: drive(I_MUL, 0, 0, 0, mk(L_MD, 1, 0, 0, 0));
        1: drive(I_MUL, 0, 0, 0, mk(L_MD, 0, 0, 1, 0));
        2: drive(I_MUL, 0, 0, 1, mk(L_RUN, 0, 0, 1, 0));
        3: drive(I_DIV, 0, 0, 0, mk(L_MD, 0, 1, 0, 0));
        4: drive(I_DIV, 0, 0, 0, mk(L_MD, 0, 0, 1, 0));
        5: drive(I_DIV, 0, 0, 1, mk(L_RUN, 0, 0, 1, 0));
        default: drive(I_ADD, 0, 0, 0, mk(L_RUN, 0, 0, 0, 0));
      endcase
      @(negedge clock);
      got = sample(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got %b required %b", k, got, exp_v);
      end
    end
  endtask

`ifdef STALL_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    logic [31:0] cnt_got[3];
    logic [31:0] cnt_exp[3];
    @(negedge clock);
    reset_n = 1'b0;
    set_in(I_ADD, 1'b0, 1'b0, 1'b0);
    #1;
    vectors++;
    if ({lw_stall_cycles, md_stall_cycles, flush_count} !== 96'd0) begin
      miscompares++;
      $display("FAIL perf_reset: got %h required 0", {lw_stall_cycles, md_stall_cycles, flush_count});
    end
    #1 reset_n = 1'b1;
    // c0..4: load/flush mix; c5..38: 33-cycle multiply with load-use hidden under it.
    for (int c = 0; c < 40; c++) begin
      if (c == 0 || c == 2 || c == 4) drive(I_ADD, 1, 0, 0, mk(L_LOAD, 0, 0, 0, 0));
      else if (c == 3)                drive(I_ADD, 1, 1, 0, mk(L_FLUSH, 0, 0, 0, 0));
      else if (c == 5)                drive(I_MUL, 0, 0, 0, mk(L_MD, 1, 0, 0, 0));
      else if (c > 5 && c < 38)       drive(I_MUL, (c <= 10), 0, 0, mk(L_MD, 0, 0, 1, 0));
      else if (c == 38)               drive(I_MUL, 0, 0, 1, mk(L_RUN, 0, 0, 1, 0));
      else                            drive(I_ADD, 0, 0, 0, mk(L_RUN, 0, 0, 0, 0));
      @(negedge clock);
      got = sample(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL perf_seq cycle %0d: got %b required %b", c, got, exp_v);
      end
    end
    cnt_got = '{lw_stall_cycles, md_stall_cycles, flush_count};
    cnt_exp = '{32'd3, 32'd33, 32'd1};
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (cnt_got[i] !== cnt_exp[i]) begin
        miscompares++;
        $display("FAIL perf_counter %0d: got %0d required %0d", i, cnt_got[i], cnt_exp[i]);
      end
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_mul();
    test_load_use();
    test_flush_priority();
    test_div_timeout();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef STALL_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
